// File: rtl/ysyx_24100005_lsu.sv
// rtl/ysyx_24100005_lsu.sv - single-outstanding RISC-V load/store unit with lane alignment and timeout
module ysyx_24100005_lsu #(
    parameter int XLEN    = 32,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_funct3,
    input  logic [XLEN-1:0]   req_addr,
    input  logic [XLEN-1:0]   req_wdata,
    output logic              rsp_valid,
    output logic [XLEN-1:0]   rsp_rdata,
    output logic              rsp_err,
    output logic              mem_req,
    output logic              mem_we,
    output logic [XLEN-1:0]   mem_addr,
    output logic [XLEN-1:0]   mem_wdata,
    output logic [XLEN/8-1:0] mem_wmask,
    input  logic              mem_gnt,
    input  logic              mem_rvalid,
    input  logic [XLEN-1:0]   mem_rdata
);
    localparam int NB  = XLEN / 8;
    localparam int OFS = $clog2(NB);
    localparam int CW  = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_RESP} state_t;

    state_t          state, state_nx;
    logic            we_q, err_q;
    logic [2:0]      f3_q;
    logic [XLEN-1:0] addr_q, wdata_q, rdata_q;
    logic [CW-1:0]   cnt;

    logic            req_ok, capture, timeout_hit;
    logic [OFS-1:0]  lane;
    logic [6:0]      ext_amt;
    logic [XLEN-1:0] shifted, load_ext;
    logic [15:0]     ones;

    function automatic logic f3_legal(input logic we, input logic [2:0] f3);
        case (f3)
            3'b000, 3'b001, 3'b010: f3_legal = 1'b1;
            3'b011:                 f3_legal = (XLEN == 64);
            3'b100, 3'b101:         f3_legal = !we;
            3'b110:                 f3_legal = !we && (XLEN == 64);
            default:                f3_legal = 1'b0;
        endcase
    endfunction

    function automatic logic misaligned(input logic [1:0] size, input logic [2:0] a);
        misaligned = (size == 2'd1 && a[0]) || (size == 2'd2 && |a[1:0]) ||
                     (size == 2'd3 && |a[2:0]);
    endfunction

    assign req_ok      = f3_legal(req_we, req_funct3) && !misaligned(req_funct3[1:0], req_addr[2:0]);
    assign capture     = (state == S_REQ && mem_gnt && mem_rvalid) || (state == S_WAIT && mem_rvalid);
    assign timeout_hit = (cnt == TO_LAST);
    assign lane        = addr_q[OFS-1:0];

    // Shift the addressed field to bit 0, then push it to the top and back to extend it.
    always_comb begin
        shifted  = rdata_q >> {lane, 3'b000};
        ext_amt  = 7'(XLEN) - (7'd8 << f3_q[1:0]);
        load_ext = f3_q[2] ? ((shifted << ext_amt) >> ext_amt)
                           : XLEN'($signed(shifted << ext_amt) >>> ext_amt);
        ones     = (16'd1 << (5'd1 << f3_q[1:0])) - 16'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= S_IDLE;
            cnt     <= '0;
            we_q    <= 1'b0;
            err_q   <= 1'b0;
            f3_q    <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state <= state_nx;
            case (state)
                S_IDLE: if (req_valid) begin
                    we_q    <= req_we;
                    f3_q    <= req_funct3;
                    addr_q  <= req_addr;
                    wdata_q <= req_wdata;
                    err_q   <= !req_ok;
                    rdata_q <= '0;
                    cnt     <= '0;
                end
                S_REQ, S_WAIT: begin
                    if (capture)          rdata_q <= mem_rdata;
                    else if (timeout_hit) err_q   <= 1'b1;
                    cnt <= cnt + CW'(1);
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_nx  = state;
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        rsp_err   = 1'b0;
        rsp_rdata = '0;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_wmask = '0;
        mem_addr  = {addr_q[XLEN-1:OFS], {OFS{1'b0}}};
        mem_wdata = wdata_q << {lane, 3'b000};
        case (state)
            S_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) state_nx = req_ok ? S_REQ : S_RESP;
            end
            S_REQ: begin
                mem_req   = 1'b1;
                mem_we    = we_q;
                mem_wmask = we_q ? NB'(ones << lane) : '0;
                if (mem_gnt && mem_rvalid) state_nx = S_RESP;
                else if (timeout_hit)      state_nx = S_RESP;
                else if (mem_gnt)          state_nx = S_WAIT;
            end
            S_WAIT: begin
                if (mem_rvalid || timeout_hit) state_nx = S_RESP;
            end
            S_RESP: begin
                rsp_valid = 1'b1;
                rsp_err   = err_q;
                rsp_rdata = (err_q || we_q) ? '0 : load_ext;
                state_nx  = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end
endmodule
